// File: rtl/avalon_ram_slave_if.sv
// Avalon-MM command/response bundle between the memory test master and the
// RAM-backed slave model.
//   master modport : drives address/writedata/read/write/burstbegin/size,
//                    observes waitrequest/readdata/readdatavalid
//   slave  modport : the mirror image
interface avalon_ram_slave_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0] avl_address;
  logic [DATA_W-1:0] avl_writedata;
  logic              avl_read;
  logic              avl_write;
  logic              avl_burstbegin;
  logic [7:0]        avl_size;
  logic              avl_waitrequest;
  logic [DATA_W-1:0] avl_readdata;
  logic              avl_readdatavalid;

  modport master (
    output avl_address, avl_writedata, avl_read, avl_write, avl_burstbegin, avl_size,
    input  avl_waitrequest, avl_readdata, avl_readdatavalid
  );

  modport slave (
    input  avl_address, avl_writedata, avl_read, avl_write, avl_burstbegin, avl_size,
    output avl_waitrequest, avl_readdata, avl_readdatavalid
  );
endinterface

// File: rtl/avalon_ram_slave_model.sv
// Avalon-MM slave standing in for the DDR controller behind the memory test
// master. Backed by 2^MEM_AW words of on-chip RAM, fixed read latency and
// LFSR-driven wait-state injection.
//
// Ports:
//   iCLK, iRST_n     clock, asynchronous active-low reset
//   avl (slave)      Avalon-MM command in, waitrequest/readdata/readdatavalid out
//   local_init_done  emulated calibration done, rises INIT_CYCLES edges after reset
//   err_flags        sticky: [0] address beyond RAM, [1] size!=1, [2] read+write
//   stall_count      saturating count of request cycles stalled after init
//
// Read timing: a read accepted on edge T loads stage 1 of the pipeline; the
// beat leaves stage RD_LAT, so readdatavalid is high for the single cycle the
// master samples on edge T+RD_LAT. RD_LAT must be 1..15, WAIT_SEED non-zero,
// INIT_CYCLES >= 1, ADDR_W >= MEM_AW.
module avalon_ram_slave_model #(
  parameter int          ADDR_W      = 26,
  parameter int          DATA_W      = 128,
  parameter int          MEM_AW      = 8,
  parameter int          RD_LAT      = 4,
  parameter bit          WAIT_EN     = 1'b1,
  parameter int          INIT_CYCLES = 64,
  parameter logic [15:0] WAIT_SEED   = 16'hACE1
) (
  input  logic         iCLK,
  input  logic         iRST_n,
  avalon_ram_slave_if.slave avl,
  output logic         local_init_done,
  output logic [2:0]   err_flags,
  output logic [15:0]  stall_count
);

  localparam int ICW = $clog2(INIT_CYCLES + 1);

  // ---------------- init emulation ----------------
  logic [ICW-1:0] init_cnt_q, init_cnt_d;
  logic           init_done_q, init_done_d;

  always_comb begin
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (!init_done_q) begin
      init_cnt_d = init_cnt_q + 1'b1;
      // counter holds the number of edges already seen since release
      if (init_cnt_q == ICW'(INIT_CYCLES - 1)) init_done_d = 1'b1;
    end
  end

  // ---------------- wait-state LFSR ----------------
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;
  logic        stall;
  logic        waitreq;

  // taps 16,14,13,11 (1-based)
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d  = init_done_q ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
  assign stall   = WAIT_EN ? (lfsr_q[0] & lfsr_q[1]) : 1'b0;
  // registers only: the master may legally look at waitrequest before
  // deciding to assert read/write
  assign waitreq = !init_done_q | stall;

  // ---------------- command decode ----------------
  logic              req;
  logic              any_acc, wr_acc, rd_acc;
  logic [MEM_AW-1:0] idx;
  logic              addr_oor;

  assign req      = avl.avl_read | avl.avl_write;
  assign any_acc  = req & !waitreq;
  assign wr_acc   = avl.avl_write & !waitreq;
  // read+write together: the write wins, the read is dropped
  assign rd_acc   = avl.avl_read & !avl.avl_write & !waitreq;
  assign idx      = avl.avl_address[MEM_AW-1:0];
  assign addr_oor = (avl.avl_address >> MEM_AW) != '0;

  // burstbegin carries no information for single-beat traffic
  logic unused_burstbegin;
  assign unused_burstbegin = avl.avl_burstbegin;

  // ---------------- RAM (not reset) ----------------
  logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];
  logic [DATA_W-1:0] rd_word;

  always_ff @(posedge iCLK) begin
    if (wr_acc) mem[idx] <= avl.avl_writedata;
  end

  // old contents are fine here: a read never executes on the same edge as a write
  assign rd_word = mem[idx];

  // ---------------- read pipeline ----------------
  // vld_pipe/dat_pipe index 0 is the beat being accepted this cycle,
  // index k the register stage k. Data stages only load with a valid beat so
  // the last stage holds the previously delivered word.
  logic [RD_LAT:1]             vld_q;
  logic [RD_LAT:1][DATA_W-1:0] dat_q;
  logic [RD_LAT:0]             vld_pipe;
  logic [RD_LAT:0][DATA_W-1:0] dat_pipe;

  assign vld_pipe = {vld_q, rd_acc};
  assign dat_pipe = {dat_q, rd_word};

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_pipe[RD_LAT-1:0];
      for (int k = 1; k <= RD_LAT; k++) begin
        if (vld_pipe[k-1]) dat_q[k] <= dat_pipe[k-1];
      end
    end
  end

  // ---------------- errors / stall statistics ----------------
  logic [2:0]  err_q, err_d;
  logic [15:0] stall_q, stall_d;
  logic        stall_ev;

  assign err_d = err_q | ({3{any_acc}} &
                          {avl.avl_read & avl.avl_write,
                           avl.avl_size != 8'd1,
                           addr_oor});

  assign stall_ev = req & waitreq & init_done_q;
  assign stall_d  = (stall_ev && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;

  // ---------------- state ----------------
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      lfsr_q      <= WAIT_SEED;
      err_q       <= '0;
      stall_q     <= '0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      lfsr_q      <= lfsr_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
    end
  end

  // ---------------- outputs ----------------
  assign avl.avl_waitrequest   = waitreq;
  assign avl.avl_readdatavalid = vld_q[RD_LAT];
  assign avl.avl_readdata      = dat_q[RD_LAT];
  assign local_init_done       = init_done_q;
  assign err_flags             = err_q;
  assign stall_count           = stall_q;

endmodule

// File: tb/tb_avalon_ram_slave_model.sv
// Directed bench: instance A (no wait states) covers init, latency, ordering,
// error flags and reset mid-read; instance B (wait states on) runs a 256-word
// write/read sweep with the bench acting as the test master.
module tb_avalon_ram_slave_model;
  logic iCLK = 1'b0;
  logic iRST_n = 1'b0;
  always #5 iCLK = ~iCLK;

  avalon_ram_slave_if #(.ADDR_W(26), .DATA_W(128)) aif();
  avalon_ram_slave_if #(.ADDR_W(26), .DATA_W(128)) bif();

  logic        a_done, b_done;
  logic [2:0]  a_err, b_err;
  logic [15:0] a_stall, b_stall;

  avalon_ram_slave_model #(.ADDR_W(26), .DATA_W(128), .MEM_AW(8), .RD_LAT(4),
    .WAIT_EN(1'b0), .INIT_CYCLES(64), .WAIT_SEED(16'hACE1)) dut_a (
    .iCLK(iCLK), .iRST_n(iRST_n), .avl(aif),
    .local_init_done(a_done), .err_flags(a_err), .stall_count(a_stall));

  avalon_ram_slave_model #(.ADDR_W(26), .DATA_W(128), .MEM_AW(8), .RD_LAT(4),
    .WAIT_EN(1'b1), .INIT_CYCLES(64), .WAIT_SEED(16'hACE1)) dut_b (
    .iCLK(iCLK), .iRST_n(iRST_n), .avl(bif),
    .local_init_done(b_done), .err_flags(b_err), .stall_count(b_stall));

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int i);
    return {4{32'hA500_0000 | 32'(i)}};
  endfunction

  initial begin
    logic seen;
    logic acc;
    int   rx, tmo;

    aif.avl_address = '0; aif.avl_writedata = '0; aif.avl_read = 0; aif.avl_write = 0;
    aif.avl_burstbegin = 0; aif.avl_size = 8'd1;
    bif.avl_address = '0; bif.avl_writedata = '0; bif.avl_read = 0; bif.avl_write = 0;
    bif.avl_burstbegin = 0; bif.avl_size = 8'd1;

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_wait",  aif.avl_waitrequest, 1);
    chk("rst_rdv",   aif.avl_readdatavalid, 0);
    chk("rst_rdata", aif.avl_readdata, 0);
    chk("rst_done",  a_done, 0);
    chk("rst_err",   a_err, 0);
    chk("rst_stall", a_stall, 0);

    // ---- init: done rises on edge 64; read held during init is never stalled-counted ----
    iRST_n = 1'b1;
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (e == 10) begin aif.avl_read = 1; aif.avl_address = 26'd0; end
      if (e == 60) aif.avl_read = 0;
      if (e == 1)  chk("init_done_e1", a_done, 0);
      if (e == 63) begin
        chk("init_done_e63", a_done, 0);
        chk("init_wait_e63", aif.avl_waitrequest, 1);
      end
      if (e == 64) begin
        chk("init_done_e64", a_done, 1);
        chk("init_wait_e64", aif.avl_waitrequest, 0);
        chk("init_b_done_e64", b_done, 1);
        chk("init_stall0", a_stall, 0);
        chk("init_rdv0", aif.avl_readdatavalid, 0);
      end
    end

    // ---- write 0x05 then read, latency 4 ----
    aif.avl_write = 1; aif.avl_address = 26'h05; aif.avl_writedata = 128'h1234;
    tick();
    aif.avl_write = 0; aif.avl_read = 1;
    tick();                                   // edge T: read accepted
    aif.avl_read = 0;
    chk("lat_t0", aif.avl_readdatavalid, 0);
    tick(); chk("lat_t1", aif.avl_readdatavalid, 0);
    tick(); chk("lat_t2", aif.avl_readdatavalid, 0);
    tick(); chk("lat_t3_v", aif.avl_readdatavalid, 1);
            chk("lat_t3_d", aif.avl_readdata, 128'h1234);
    tick(); chk("lat_t4_v", aif.avl_readdatavalid, 0);
            chk("lat_hold", aif.avl_readdata, 128'h1234);

    // ---- preload 0..7, then 8 back-to-back reads ----
    for (int i = 0; i < 8; i++) begin
      aif.avl_write = 1; aif.avl_address = 26'(i); aif.avl_writedata = 128'(i);
      tick();
    end
    aif.avl_write = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin aif.avl_read = 1; aif.avl_address = 26'(i); end
      else aif.avl_read = 0;
      tick();
      chk($sformatf("b2b_v%0d", i), aif.avl_readdatavalid, (i >= 3) ? 1 : 0);
      if (i >= 3) chk($sformatf("b2b_d%0d", i), aif.avl_readdata, 128'(i - 3));
    end
    tick(); chk("b2b_end", aif.avl_readdatavalid, 0);

    // ---- out-of-range address wraps ----
    aif.avl_write = 1; aif.avl_address = 26'h100; aif.avl_writedata = 128'hDEAD_BEEF_0000_0100;
    tick();
    aif.avl_write = 0;
    chk("oor_err", a_err, 3'b001);
    aif.avl_read = 1; aif.avl_address = 26'h000;
    tick();
    aif.avl_read = 0;
    repeat (3) tick();
    chk("oor_rd_v", aif.avl_readdatavalid, 1);
    chk("oor_rd_d", aif.avl_readdata, 128'hDEAD_BEEF_0000_0100);
    chk("oor_err_keep", a_err, 3'b001);

    // ---- size != 1 executes as one beat ----
    aif.avl_read = 1; aif.avl_address = 26'h002; aif.avl_size = 8'd8;
    tick();
    aif.avl_read = 0; aif.avl_size = 8'd1;
    chk("size_err", a_err, 3'b011);
    repeat (3) tick();
    chk("size_rd_v", aif.avl_readdatavalid, 1);
    chk("size_rd_d", aif.avl_readdata, 128'd2);
    tick(); chk("size_single", aif.avl_readdatavalid, 0);

    // ---- read+write together: write wins, no readdatavalid ----
    aif.avl_read = 1; aif.avl_write = 1; aif.avl_address = 26'h003; aif.avl_writedata = 128'hBB33;
    tick();
    aif.avl_read = 0; aif.avl_write = 0;
    chk("rw_err", a_err, 3'b111);
    seen = 0;
    repeat (6) begin tick(); seen |= aif.avl_readdatavalid; end
    chk("rw_no_rdv", seen, 0);
    aif.avl_read = 1; aif.avl_address = 26'h003;
    tick();
    aif.avl_read = 0;
    repeat (3) tick();
    chk("rw_wr_v", aif.avl_readdatavalid, 1);
    chk("rw_wr_d", aif.avl_readdata, 128'hBB33);
    chk("a_stall_zero", a_stall, 0);

    // ---- instance B: 256 writes then 256 reads under wait states ----
    tmo = 0;
    for (int i = 0; i < 256; i++) begin
      bif.avl_write = 1; bif.avl_address = 26'(i); bif.avl_writedata = pat(i);
      acc = 0;
      for (int n = 0; n < 64 && !acc; n++) begin
        acc = !bif.avl_waitrequest;          // accepted on the coming edge
        tick();
      end
      if (!acc) tmo++;
    end
    bif.avl_write = 0;
    rx = 0;
    for (int i = 0; i < 256; i++) begin
      bif.avl_read = 1; bif.avl_address = 26'(i);
      acc = 0;
      for (int n = 0; n < 64 && !acc; n++) begin
        acc = !bif.avl_waitrequest;
        tick();
        if (bif.avl_readdatavalid) begin
          chk($sformatf("b_rd%0d", rx), bif.avl_readdata, pat(rx));
          rx++;
        end
      end
      if (!acc) tmo++;
    end
    bif.avl_read = 0;
    repeat (20) begin
      tick();
      if (bif.avl_readdatavalid) begin
        chk($sformatf("b_rd%0d", rx), bif.avl_readdata, pat(rx));
        rx++;
      end
    end
    chk("b_timeouts", tmo, 0);
    chk("b_rx_count", rx, 256);
    chk("b_stall_nz", b_stall != 16'd0, 1);
    chk("b_err", b_err, 3'b000);

    // ---- reset with 3 reads in flight ----
    for (int i = 0; i < 3; i++) begin
      aif.avl_read = 1; aif.avl_address = 26'(i);
      tick();
    end
    aif.avl_read = 0;
    iRST_n = 1'b0;
    #1;
    chk("mid_rst_done", a_done, 0);
    chk("mid_rst_wait", aif.avl_waitrequest, 1);
    chk("mid_rst_err", a_err, 0);
    seen = aif.avl_readdatavalid;
    repeat (2) begin tick(); seen |= aif.avl_readdatavalid; end
    iRST_n = 1'b1;
    for (int e = 1; e <= 64; e++) begin
      tick();
      seen |= aif.avl_readdatavalid;
      if (e == 63) chk("reinit_e63", a_done, 0);
      if (e == 64) chk("reinit_e64", a_done, 1);
    end
    repeat (8) begin tick(); seen |= aif.avl_readdatavalid; end
    chk("mid_rst_no_rdv", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/avalon_ram_slave_model.md
Name: avalon_ram_slave_model

Overview:
- Synthesizable Avalon-MM slave that stands in for the DDR controller directly downstream of the memory read/write test master.
- Consumes the master's address, writedata, read, write, burstbegin and size signals. Returns waitrequest, readdata and readdatavalid.
- Backed by on-chip RAM, with a programmable read latency and pseudo-random wait-state injection. Used for board bring-up and to exercise the master's handshake without external memory.

Parameters:
- ADDR_W, 26, Avalon word-address width.
- DATA_W, 128, data width.
- MEM_AW, 8, implemented RAM address bits; depth is 2^MEM_AW words.
- RD_LAT, 4, cycles from read accept to readdatavalid; legal range 1..15.
- WAIT_EN, 1, 1 enables random wait-state injection.
- INIT_CYCLES, 64, cycles after reset release before local_init_done rises.
- WAIT_SEED, 16'hACE1, seed for the wait-state LFSR; must be non-zero.

Ports:
- iCLK  in  1  clock
- iRST_n  in  1  reset, asynchronous, active-low
- avl_address  in  ADDR_W  word address
- avl_writedata  in  DATA_W  write data
- avl_read  in  1  read request
- avl_write  in  1  write request
- avl_burstbegin  in  1  burst start marker; ignored
- avl_size  in  8  burst length; only 1 supported
- avl_waitrequest  out  1  active-high stall
- avl_readdata  out  DATA_W  read data
- avl_readdatavalid  out  1  read data valid
- local_init_done  out  1  calibration-complete emulation
- err_flags  out  3  sticky errors: [0] address out of range, [1] size!=1, [2] read and write asserted together
- stall_count  out  16  saturating count of stalled request cycles

Behaviour:
- Reset is asynchronous and active-low on iRST_n; clock is iCLK.
- Reset values of outputs:
  - avl_waitrequest=1, avl_readdatavalid=0, avl_readdata=0, local_init_done=0, err_flags=0, stall_count=0.
  - Read pipeline valids clear. LFSR loads WAIT_SEED. Init counter clears.
  - RAM contents are not reset.
- Init:
  - A counter increments from reset release.
  - local_init_done is registered and rises on the INIT_CYCLES-th rising edge after reset release, then stays 1 until reset.
  - avl_waitrequest is held 1 while local_init_done=0.
- Wait injection:
  - 16-bit Fibonacci LFSR with taps 16,14,13,11 advances every cycle once local_init_done=1.
  - stall = WAIT_EN & lfsr[0] & lfsr[1], i.e. about 25% of cycles.
  - avl_waitrequest = !local_init_done | stall. It is combinational from registers only and never depends on read/write.
- Accept: a command is accepted on an edge where (avl_read|avl_write) & !avl_waitrequest.
- Write accept:
  - Writes RAM[avl_address[MEM_AW-1:0]] <= avl_writedata at that edge.
- Read accept:
  - Samples the RAM at that edge.
  - avl_readdatavalid is 1 for exactly one cycle, starting RD_LAT cycles after the accept edge.
  - Data is returned in order, one beat per accepted read.
  - Back-to-back accepts produce back-to-back valids. The pipeline is a RD_LAT-deep shift register of {valid, data}, so there is no backpressure and no overflow.
- Read-after-write: a write accepted at edge T followed by a read of the same address accepted at T+1 or later returns the new data.
- avl_readdata holds the last delivered value while avl_readdatavalid=0.
- Address above 2^MEM_AW-1 on accept: the address wraps (uses the low bits), the command executes, and err_flags[0] is set.
- avl_size != 1 on accept: executes as a single beat and sets err_flags[1].
- avl_read & avl_write both asserted on accept: the write executes, the read is dropped (no readdatavalid), and err_flags[2] is set.
- stall_count: increments on each cycle with (avl_read|avl_write) & avl_waitrequest & local_init_done, and saturates at 16'hFFFF.
- Reset mid-operation:
  - In-flight reads are discarded; no readdatavalid appears after reset.
  - The init sequence restarts; local_init_done drops immediately.

Test Plan:
1. Release reset with WAIT_EN=0 and INIT_CYCLES=64 -> local_init_done=0 and waitrequest=1 through edge 63; both change on edge 64; stall_count stays 0.
2. WAIT_EN=0, RD_LAT=4: write addr 0x05 data 128'h1234, then read addr 0x05 accepted at edge T -> readdatavalid high only in cycle T+4 with readdata=128'h1234; the value holds afterward.
3. WAIT_EN=0: 8 back-to-back reads of addresses 0..7 preloaded with data=address -> 8 consecutive valid cycles returning 0..7 in order, with no gaps.
4. WAIT_EN=1: drive the test master for 256 writes then 256 reads -> all data matches, the master reports pass, stall_count>0, and every request held until waitrequest=0.
5. Write to address 0x100 with MEM_AW=8, then read address 0x000 -> returns the written data; err_flags=3'b001. Then issue a command with avl_size=8 -> err_flags=3'b011. Then assert read and write together -> err_flags=3'b111 and no readdatavalid.
6. Assert iRST_n low one cycle after 3 reads are accepted -> no readdatavalid ever appears; local_init_done drops immediately and re-rises 64 edges after release.
